// File: rtl/mem_arbiter_if.sv
// Cache-pair / RAM bus bundle shared by the memory arbiter.
// The arbiter takes the slave side; the cache/RAM environment takes the master side.
interface mem_arbiter_if;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;
    logic        err;

    modport slave (
        input  iREN, iaddr,
        input  dREN, dWEN, daddr, dstore,
        input  ramload, ramstate,
        output iwait, iload,
        output dwait, dload,
        output ramREN, ramWEN, ramaddr, ramstore,
        output err
    );

    modport master (
        output iREN, iaddr,
        output dREN, dWEN, daddr, dstore,
        output ramload, ramstate,
        input  iwait, iload,
        input  dwait, dload,
        input  ramREN, ramWEN, ramaddr, ramstore,
        input  err
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin icache/dcache arbiter in front of the single-port RAM,
// with a watchdog that aborts RAM accesses that never complete.
module mem_arbiter #(
    parameter int TIMEOUT = 64,
    parameter int CW      = 7
) (
    input  logic          CLK,
    input  logic          RST,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISERV = 2'd1,
        DSERV = 2'd2
    } state_t;

    localparam logic [1:0]    RS_ACCESS = 2'd2;
    localparam logic [1:0]    RS_ERROR  = 2'd3;
    localparam logic [CW-1:0] WD_LAST   = CW'(TIMEOUT - 1);

    state_t        r_state;
    state_t        w_next;
    logic          r_last_d;
    logic [CW-1:0] r_wdog;
    logic          r_err;

    logic          w_ipend;
    logic          w_dpend;
    logic          w_access;
    logic          w_error;
    logic          w_expire;
    logic          w_set_err;

    logic          w_iwait;
    logic          w_dwait;
    logic [31:0]   w_iload;
    logic [31:0]   w_dload;
    logic          w_ramREN;
    logic          w_ramWEN;
    logic [31:0]   w_ramaddr;
    logic [31:0]   w_ramstore;

    assign w_ipend  = bus.iREN;
    assign w_dpend  = bus.dREN | bus.dWEN;
    assign w_access = (bus.ramstate == RS_ACCESS);
    assign w_error  = (bus.ramstate == RS_ERROR);
    assign w_expire = (r_wdog == WD_LAST);

    always_comb begin
        w_next     = r_state;
        w_set_err  = 1'b0;
        w_iwait    = 1'b1;
        w_dwait    = 1'b1;
        w_iload    = '0;
        w_dload    = '0;
        w_ramREN   = 1'b0;
        w_ramWEN   = 1'b0;
        w_ramaddr  = '0;
        w_ramstore = '0;
        unique case (r_state)
            IDLE: begin
                // D wins a tie unless it was the last one served
                if (w_dpend && (!w_ipend || !r_last_d)) begin
                    w_next = DSERV;
                end else if (w_ipend) begin
                    w_next = ISERV;
                end
            end
            ISERV: begin
                w_ramREN  = bus.iREN;
                w_ramaddr = bus.iaddr;
                if (!w_ipend) begin
                    w_next = IDLE;
                end else if (w_access) begin
                    w_iwait = 1'b0;
                    w_iload = bus.ramload;
                    w_next  = IDLE;
                end else if (w_error || w_expire) begin
                    w_set_err = 1'b1;
                    w_next    = IDLE;
                end
            end
            DSERV: begin
                w_ramWEN   = bus.dWEN;
                w_ramREN   = bus.dREN & ~bus.dWEN;
                w_ramaddr  = bus.daddr;
                w_ramstore = bus.dstore;
                if (!w_dpend) begin
                    w_next = IDLE;
                end else if (w_access) begin
                    w_dwait = 1'b0;
                    w_dload = bus.ramload;
                    w_next  = IDLE;
                end else if (w_error || w_expire) begin
                    w_set_err = 1'b1;
                    w_next    = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= IDLE;
            r_last_d <= 1'b0;
            r_wdog   <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_set_err) begin
                r_err <= 1'b1;
            end
            // wdog is held at zero in IDLE so every grant starts fresh
            if (r_state == IDLE) begin
                r_wdog <= '0;
                if (w_next != IDLE) begin
                    r_last_d <= (w_next == DSERV);
                end
            end else if (!w_access) begin
                r_wdog <= r_wdog + CW'(1);
            end
        end
    end

    assign bus.iwait    = w_iwait;
    assign bus.iload    = w_iload;
    assign bus.dwait    = w_dwait;
    assign bus.dload    = w_dload;
    assign bus.ramREN   = w_ramREN;
    assign bus.ramWEN   = w_ramWEN;
    assign bus.ramaddr  = w_ramaddr;
    assign bus.ramstore = w_ramstore;
    assign bus.err      = r_err;
endmodule
